// File: rtl/video_timing_align.sv
// video_timing_align: re-aligns source video timing with the output of the
// 3x3 window filter, blacks out window-border pixels and keeps active video
// black until the frame format has been measured as stable.
//
// Ports
//   Clock, Reset        pixel clock, asynchronous active-low reset
//   i_pixelData [23:0]  filtered pixel from the window filter
//   i_rawPixel  [23:0]  unfiltered pixel, aligned with the i_* timing inputs
//   i_HSync/i_VSync/i_HBlank/i_VBlank/i_VDE  source timing
//   o_pixelData [23:0]  aligned output pixel
//   o_HSync/o_VSync/o_HBlank/o_VBlank/o_VDE  timing delayed by LATENCY cycles
//   o_locked            high while the FSM is in RUN
//   o_fmtChange         one-cycle pulse on a line-length / line-count change
//
// Build option: define BORDER_MASK_EN to include the border masking logic;
// without it BORDER is ignored and locked active video passes i_pixelData.
module video_timing_align #(
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned XADRSWidth = 11,
    parameter int unsigned YADRSWidth = 10,
    parameter int unsigned BORDER     = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [23:0] i_pixelData,
    input  logic [23:0] i_rawPixel,
    input  logic        i_HSync,
    input  logic        i_VSync,
    input  logic        i_HBlank,
    input  logic        i_VBlank,
    input  logic        i_VDE,
    output logic [23:0] o_pixelData,
    output logic        o_HSync,
    output logic        o_VSync,
    output logic        o_HBlank,
    output logic        o_VBlank,
    output logic        o_VDE,
    output logic        o_locked,
    output logic        o_fmtChange
);

    localparam int unsigned DW = 29;

    typedef enum logic [1:0] {WAIT_VS, MEASURE, RUN} state_t;

    // Elaboration-time parameter sanity checks
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("video_timing_align: LATENCY must be 1..15");
    end
    if (BORDER >= (32'd1 << YADRSWidth)) begin : g_bad_border
        $error("video_timing_align: BORDER does not fit the counters");
    end

    // Delay line over timing + raw pixel; the output registers form the
    // final stage, so 'cur' is the stage feeding them and the previous
    // value of every delayed timing bit is simply the matching o_* register.
    logic [DW-1:0] tap_in;
    logic [DW-1:0] cur;

    assign tap_in = {i_HSync, i_VSync, i_HBlank, i_VBlank, i_VDE, i_rawPixel};

    if (LATENCY > 1) begin : g_dly
        logic [DW-1:0] sr [LATENCY-1];
        always_ff @(posedge Clock or negedge Reset) begin
            if (!Reset) begin
                for (int i = 0; i < int'(LATENCY) - 1; i++) sr[i] <= '0;
            end else begin
                sr[0] <= tap_in;
                for (int i = 1; i < int'(LATENCY) - 1; i++) sr[i] <= sr[i-1];
            end
        end
        assign cur = sr[LATENCY-2];
    end else begin : g_nodly
        assign cur = tap_in;
    end

    logic        d_hs, d_vs, d_hb, d_vb, d_vde;
    logic [23:0] d_raw;
    assign {d_hs, d_vs, d_hb, d_vb, d_vde, d_raw} = cur;

    logic vde_fall_c;
    logic vs_rise_c;
    assign vde_fall_c = !d_vde && o_VDE;
    assign vs_rise_c  = d_vs && !o_VSync;

    logic [XADRSWidth-1:0] hcnt, line_len;
    logic [YADRSWidth-1:0] vcnt, frame_lines;
    logic                  first_line, len_ok;
    logic                  len_mis_c;

    // hcnt already includes the last active pixel when the fall is seen,
    // so it is the completed line length.
    assign len_mis_c = (hcnt != line_len);

    // Position counters, format measurement and per-frame stability tracking
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            hcnt        <= '0;
            vcnt        <= '0;
            line_len    <= '0;
            frame_lines <= '0;
            first_line  <= 1'b1;
            len_ok      <= 1'b0;
        end else begin
            if (vde_fall_c) begin
                hcnt     <= '0;
                line_len <= hcnt;
            end else if (d_vde && (hcnt != '1)) begin
                hcnt <= hcnt + XADRSWidth'(1);
            end

            if (vs_rise_c) begin
                vcnt        <= '0;
                frame_lines <= vcnt;
            end else if (vde_fall_c && (vcnt != '1)) begin
                vcnt <= vcnt + YADRSWidth'(1);
            end

            // First line of a frame only sets the reference length
            if (vs_rise_c) begin
                first_line <= 1'b1;
                len_ok     <= 1'b1;
            end else if (vde_fall_c) begin
                first_line <= 1'b0;
                if (!first_line && len_mis_c) len_ok <= 1'b0;
            end
        end
    end

    state_t state, state_nxt;
    logic   fmt_c;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= WAIT_VS;
        else        state <= state_nxt;
    end

    // Lock FSM; a single pulse covers simultaneous length and count mismatches
    always_comb begin
        state_nxt = state;
        fmt_c     = 1'b0;
        case (state)
            WAIT_VS: begin
                if (vs_rise_c) state_nxt = MEASURE;
            end
            MEASURE: begin
                if (vs_rise_c && len_ok && (vcnt != '0)) state_nxt = RUN;
            end
            RUN: begin
                if ((vde_fall_c && len_mis_c) ||
                    (vs_rise_c && (vcnt != frame_lines))) begin
                    state_nxt = MEASURE;
                    fmt_c     = 1'b1;
                end
            end
            default: state_nxt = WAIT_VS;
        endcase
    end

`ifdef BORDER_MASK_EN
    localparam logic [XADRSWidth-1:0] BX = XADRSWidth'(BORDER);
    localparam logic [YADRSWidth-1:0] BY = YADRSWidth'(BORDER);

    // Border hit; a border at least as wide as the line/frame masks all of it
    logic border_hit_c;
    always_comb begin
        border_hit_c = 1'b0;
        if (BORDER != 0) begin
            border_hit_c = (hcnt < BX) || (BX >= line_len) || (hcnt >= line_len - BX) ||
                           (vcnt < BY) || (BY >= frame_lines) || (vcnt >= frame_lines - BY);
        end
    end
`endif

    // Output pixel selection
    logic [23:0] pix_c;
    always_comb begin
        pix_c = i_pixelData;
        if (!d_vde) begin
            pix_c = d_raw;
        end else if (state != RUN) begin
            pix_c = '0;
        end
`ifdef BORDER_MASK_EN
        else if (border_hit_c) begin
            pix_c = '0;
        end
`endif
    end

    // Output stage: last tap of the timing delay plus the selected pixel
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            o_pixelData <= '0;
            o_HSync     <= 1'b0;
            o_VSync     <= 1'b0;
            o_HBlank    <= 1'b0;
            o_VBlank    <= 1'b0;
            o_VDE       <= 1'b0;
            o_locked    <= 1'b0;
            o_fmtChange <= 1'b0;
        end else begin
            o_pixelData <= pix_c;
            o_HSync     <= d_hs;
            o_VSync     <= d_vs;
            o_HBlank    <= d_hb;
            o_VBlank    <= d_vb;
            o_VDE       <= d_vde;
            o_locked    <= (state_nxt == RUN);
            o_fmtChange <= fmt_c;
        end
    end

endmodule
